// File: rtl/sensor_scanner.sv
// Purpose : polls four height sensors over a shared sel/req/ack bus and publishes an atomic snapshot.
// Latency : a full scan takes at least 10 cycles; scans start no closer than SCAN_PERIOD cycles apart.
// Backpressure: none toward the consumer; a silent or stuck sensor is bounded by TIMEOUT and reported as 0 plus a fault bit.
module sensor_scanner #(
  parameter int SCAN_PERIOD = 1000,
  parameter int TIMEOUT     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] sel,
  output logic       req,
  input  logic       ack,
  input  logic [7:0] data,
  output logic [7:0] sensor1,
  output logic [7:0] sensor2,
  output logic [7:0] sensor3,
  output logic [7:0] sensor4,
  output logic [3:0] fault,
  output logic       snap_valid,
  output logic       busy
);

  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, REL, PUB} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pcnt;
  logic [TW-1:0]   tcnt;
  logic [3:0][7:0] shadow;
  logic [3:0]      fault_sh;

  logic            tmo;
  logic            start;
  logic            cap;
  logic [7:0]      cap_dat;
  logic            cap_flt;
  logic            clr_t;
  logic            inc_t;
  logic            adv;

  assign tmo  = (tcnt == TW'(TIMEOUT - 1));
  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle actions; ack wins over a coinciding timeout in both bus phases
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    cap       = 1'b0;
    cap_dat   = data;
    cap_flt   = 1'b0;
    clr_t     = 1'b0;
    inc_t     = 1'b0;
    adv       = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && (pcnt == '0)) begin
          start     = 1'b1;
          clr_t     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          cap       = 1'b1;
          clr_t     = 1'b1;
          state_nxt = REL;
        end else if (tmo) begin
          cap       = 1'b1;
          cap_dat   = 8'h00;
          cap_flt   = 1'b1;
          clr_t     = 1'b1;
          state_nxt = REL;
        end else begin
          inc_t = 1'b1;
        end
      end
      REL: begin
        if (!ack || tmo) begin
          // ack still high at the deadline: the sensor never let go, so its earlier capture is discarded
          if (ack) begin
            cap     = 1'b1;
            cap_dat = 8'h00;
            cap_flt = 1'b1;
          end
          clr_t = 1'b1;
          if (sel == 2'd3) begin
            state_nxt = PUB;
          end else begin
            adv       = 1'b1;
            state_nxt = REQ;
          end
        end else begin
          inc_t = 1'b1;
        end
      end
      PUB: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counters, bus drive and per-sensor shadow capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt     <= '0;
      tcnt     <= '0;
      sel      <= 2'd0;
      req      <= 1'b0;
      shadow   <= '0;
      fault_sh <= 4'h0;
    end else begin
      if (start)            pcnt <= PW'(SCAN_PERIOD - 1);
      else if (pcnt != '0)  pcnt <= pcnt - PW'(1);

      if (clr_t)      tcnt <= '0;
      else if (inc_t) tcnt <= tcnt + TW'(1);

      if (start)    sel <= 2'd0;
      else if (adv) sel <= sel + 2'd1;

      req <= (state_nxt == REQ);

      if (cap) begin
        shadow[sel]   <= cap_dat;
        fault_sh[sel] <= cap_flt;
      end
    end
  end

  // Publish: all four readings and faults move together, snap_valid marks the first cycle they are visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sensor1    <= 8'h00;
      sensor2    <= 8'h00;
      sensor3    <= 8'h00;
      sensor4    <= 8'h00;
      fault      <= 4'h0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= (state == PUB);
      if (state == PUB) begin
        sensor1 <= shadow[0];
        sensor2 <= shadow[1];
        sensor3 <= shadow[2];
        sensor4 <= shadow[3];
        fault   <= fault_sh;
      end
    end
  end

endmodule

// File: tb/tb_sensor_scanner.sv
// Bench for sensor_scanner: per-sensor bus model (normal with latency, dead, stuck) and
// an outcome model (value or 0, fault bit, req-high cycles, start spacing) checked per scan.
// Directed scenarios first, then randomized scans, then mid-scan reset and enable drop.
module tb_sensor_scanner;
  localparam int SP = 50;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] sel;
  logic       req;
  logic [7:0] s1, s2, s3, s4;
  logic [3:0] fault;
  logic       snap_valid;
  logic       busy;

  sensor_scanner #(.SCAN_PERIOD(SP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .req(req), .ack(ack), .data(data),
    .sensor1(s1), .sensor2(s2), .sensor3(s3), .sensor4(s4),
    .fault(fault), .snap_valid(snap_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // sensor behaviour: mode 0 = answers after lat cycles, 1 = dead, 2 = ack stuck high
  int         mode[4];
  int         lat[4];
  logic [7:0] vals[4];
  logic       ackst[4];
  int         dly[4];

  // monitor state
  int          cyc = 0;
  int          req_rises = 0;
  int          bad_chg = 0;
  int          double_snap = 0;
  int          reqcyc[4];
  int          starts[$];
  logic        prev_busy = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_snap = 1'b0;
  logic [35:0] prev_out = '0;

  int base_rises;
  int base_cyc[4];

  // bus model: each sensor sees req only while selected, answers and releases after its latency
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (mode[i] == 2) ackst[i] = 1'b1;
        else if (mode[i] == 1) ackst[i] = 1'b0;
        else if ((req && (sel == 2'(i))) != ackst[i]) begin
          if (dly[i] >= lat[i]) begin
            ackst[i] = ~ackst[i];
            dly[i] = 0;
          end else dly[i]++;
        end else dly[i] = 0;
      end
      ack  = ackst[sel];
      data = ackst[sel] ? vals[sel] : 8'($urandom);
    end
  end

  // monitor sampling pre-edge values at each rising edge
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      prev_busy = 1'b0;
      prev_req  = 1'b0;
      prev_snap = 1'b0;
      prev_out  = {s1, s2, s3, s4, fault};
    end else begin
      if (busy && !prev_busy) starts.push_back(cyc);
      if (req && !prev_req) req_rises++;
      if (req) reqcyc[sel]++;
      if (({s1, s2, s3, s4, fault} != prev_out) && !snap_valid) bad_chg++;
      if (snap_valid && prev_snap) double_snap++;
      prev_busy = busy;
      prev_req  = req;
      prev_snap = snap_valid;
      prev_out  = {s1, s2, s3, s4, fault};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic take_base();
    base_rises = req_rises;
    for (int i = 0; i < 4; i++) base_cyc[i] = reqcyc[i];
  endtask

  task automatic wait_snap(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (snap_valid) seen = 1'b1;
    end
    check({tag, "_snap_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_sel(input logic [1:0] s, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (busy && req && sel == s) seen = 1'b1;
    end
    check({tag, "_sel_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_scan(input string tag, input bit gap);
    logic [7:0] ev[4];
    logic [3:0] ef;
    int         er;
    for (int i = 0; i < 4; i++) begin
      ev[i] = (mode[i] == 0) ? vals[i] : 8'h00;
      ef[i] = (mode[i] != 0);
    end
    check({tag, "_sensor1"}, 32'(s1), 32'(ev[0]));
    check({tag, "_sensor2"}, 32'(s2), 32'(ev[1]));
    check({tag, "_sensor3"}, 32'(s3), 32'(ev[2]));
    check({tag, "_sensor4"}, 32'(s4), 32'(ev[3]));
    check({tag, "_fault"}, 32'(fault), 32'(ef));
    check({tag, "_req_rises"}, 32'(req_rises - base_rises), 32'd4);
    for (int i = 0; i < 4; i++) begin
      er = (mode[i] == 1) ? TO : (mode[i] == 2) ? 1 : lat[i] + 1;
      check($sformatf("%s_reqcyc%0d", tag, i), 32'(reqcyc[i] - base_cyc[i]), 32'(er));
    end
    if (gap) check({tag, "_start_gap"}, 32'(starts[$] - starts[$-1]), 32'(SP));
    take_base();
  endtask

  task automatic set_all(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d);
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    for (int i = 0; i < 4; i++) begin
      mode[i] = 0;
      lat[i]  = 0;
    end
  endtask

  task automatic set_random();
    int b;
    for (int i = 0; i < 4; i++) begin
      mode[i] = 0;
      lat[i]  = $urandom_range(0, 3);
      vals[i] = 8'($urandom);
    end
    if ($urandom_range(0, 1) == 1) begin
      b = $urandom_range(0, 3);
      mode[b] = $urandom_range(1, 2);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ackst[i] = 1'b0;
      dly[i] = 0;
      reqcyc[i] = 0;
    end
    set_all(8'd40, 8'd42, 8'd44, 8'd46);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_bus", {29'd0, req, sel}, 32'd0);
    check("rst_flags", {30'd0, busy, snap_valid}, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_sensors", {s1, s2, s3, s4}, 32'd0);

    // all sensors answer one cycle after req
    take_base();
    #1;
    en  = 1'b1;
    rst = 1'b0;
    wait_snap("t1");
    check_scan("t1", 1'b0);

    // sensor 3 dead
    set_all(8'd10, 8'd20, 8'd30, 8'd40);
    mode[2] = 1;
    wait_snap("t2");
    check_scan("t2", 1'b1);

    // sensor 2 stuck high, sensor 4 genuinely reads 0
    set_all(8'd7, 8'd99, 8'd55, 8'd0);
    mode[1] = 2;
    wait_snap("t3");
    check_scan("t3", 1'b1);

    // back-to-back scans with new data
    set_all(8'd1, 8'd2, 8'd3, 8'd4);
    wait_snap("t4a");
    check_scan("t4a", 1'b1);
    set_all(8'hf1, 8'hf2, 8'hf3, 8'hf4);
    lat[3] = 3;
    wait_snap("t4b");
    check_scan("t4b", 1'b1);

    // randomized scans
    for (int k = 0; k < 6; k++) begin
      set_random();
      wait_snap($sformatf("rnd%0d", k));
      check_scan($sformatf("rnd%0d", k), 1'b1);
    end

    // asynchronous reset while sel=2 in REQ
    set_random();
    wait_sel(2'd2, "t5");
    #2;
    rst = 1'b1;
    #1;
    check("t5_bus", {29'd0, req, sel}, 32'd0);
    check("t5_flags", {30'd0, busy, snap_valid}, 32'd0);
    check("t5_out", {s1, s2, s3, s4}, 32'd0);
    check("t5_fault", 32'(fault), 32'd0);
    @(negedge clk);
    @(negedge clk);
    set_all(8'd11, 8'd22, 8'd33, 8'd44);
    take_base();
    #1;
    rst = 1'b0;
    wait_sel(2'd0, "t5_restart");
    check("t5_restart_sel", 32'(sel), 32'd0);
    wait_snap("t5");
    check_scan("t5", 1'b0);

    // enable drops during sel=1: scan completes, nothing further until re-enabled
    set_random();
    wait_sel(2'd1, "t6");
    en = 1'b0;
    wait_snap("t6");
    check_scan("t6", 1'b1);
    begin
      int ns;
      ns = starts.size();
      repeat (150) @(negedge clk);
      check("t6_no_start", 32'(starts.size()), 32'(ns));
      check("t6_no_req", 32'(req_rises - base_rises), 32'd0);
      check("t6_idle", {30'd0, busy, req}, 32'd0);
    end
    set_all(8'd5, 8'd6, 8'd7, 8'd8);
    en = 1'b1;
    wait_sel(2'd0, "t6_resume");
    wait_snap("t6_resume");
    check_scan("t6_resume", 1'b0);

    // snapshot stability over the whole run
    check("stable_outputs", 32'(bad_chg), 32'd0);
    check("single_pulse", 32'(double_snap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_scanner.md
Name: sensor_scanner

Overview:
- Acquisition front end of the baggage-drop datapath.
- Polls the four height sensors over a shared, sensor-select, four-phase req/ack bus and collects one byte per sensor.
- Presents the four readings as a stable, atomically updated snapshot (sensor1..sensor4) to the height computation.
- A sensor that does not answer within a timeout is reported as value 0, the team's dead-sensor encoding, and is flagged in fault.

Parameters:
SCAN_PERIOD, 1000, minimum cycles between consecutive scan starts (>=8)
TIMEOUT, 16, cycles allowed for ack to rise (REQ) or fall (REL) before the sensor is declared faulty (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  scan enable; sampled only in IDLE
sel  output  2  sensor index on the bus (0..3 maps to sensor1..sensor4)
req  output  1  bus request, registered
ack  input  1  bus acknowledge from the selected sensor
data  input  8  sensor byte, valid while ack=1
sensor1  output  8  snapshot reading, sensor 1
sensor2  output  8  snapshot reading, sensor 2
sensor3  output  8  snapshot reading, sensor 3
sensor4  output  8  snapshot reading, sensor 4
fault  output  4  bit i=1: sensor i+1 timed out in the last published scan
snap_valid  output  1  one-cycle pulse when a new snapshot is published
busy  output  1  high in any state except IDLE

Behaviour:
- Interface decided: one clock, clk; reset rst is asynchronous and active-high.
- Reset (asynchronous, takes effect immediately, including mid-scan):
  - State=IDLE, sel=0, req=0.
  - sensor1..4=0, shadows=0, fault=0, snap_valid=0, busy=0.
  - Period counter=0, timeout counter=0.
  - Any partial scan is discarded.
- Period counter:
  - Decrements each cycle and saturates at 0.
  - Reloads to SCAN_PERIOD-1 on the cycle a scan starts.
- State IDLE:
  - If en=1 and the period counter is 0: start scan, sel<=0, timeout counter cleared, go to REQ.
  - req rises the cycle after the start condition.
- State REQ (req=1, sel held stable):
  - ack=1 sampled: shadow[sel]<=data, fault_shadow[sel]<=0, go to REL.
  - Else, timeout counter reaches TIMEOUT-1: shadow[sel]<=0, fault_shadow[sel]<=1, go to REL.
  - Else: increment the timeout counter.
- State REL (req=0):
  - Exits when ack=0 is sampled or after TIMEOUT cycles. A release timeout also sets fault_shadow[sel] and forces shadow[sel]=0.
  - Exit with sel<3: sel<=sel+1, clear the timeout counter, go to REQ.
  - Exit with sel=3: go to PUB.
- State PUB (one cycle):
  - Copy shadow[0..3] to sensor1..4 and fault_shadow to fault in the same edge.
  - snap_valid=1 for exactly this one cycle; go to IDLE.
- Snapshot stability: sensor1..4 and fault change only on the PUB edge and never show a mix of two scans.
- ack already high on entering REQ (stuck sensor): captured immediately. That sensor then normally times out in REL and is flagged.
- en dropping mid-scan does not abort the scan; it only prevents the next start.
- A genuine reading of 0 with a timely ack gives value 0 with the fault bit clear.
- sel wraps only via the return to IDLE; sel resets to 0 at each scan start.
- Minimum scan time with ack responding immediately: 1 (IDLE) + 4x(REQ 1 + REL 1) + 1 (PUB) = 10 cycles.
- A scan longer than SCAN_PERIOD starts the next scan the cycle after returning to IDLE.

Test Plan:
1. Reset, en=1; bus model acks one cycle after req with data 40,42,44,46 -> snap_valid pulses once; sensor1..4=40,42,44,46; fault=0; req toggles exactly 4 times.
2. Sensor 3 never acks, TIMEOUT=16 -> sensor3=0, fault=4'b0100, other values correct; req stays high 16 cycles for sel=2.
3. Sensor 2 holds ack high permanently -> sensor2 captured data then forced to 0, fault=4'b0010; next sel=2 proceeds after the REL timeout.
4. Two back-to-back scans with SCAN_PERIOD=50 and changed data; sample outputs every cycle -> values switch only on the snap_valid cycle; scan starts are exactly 50 cycles apart.
5. Assert rst while sel=2 in REQ -> req, sel, outputs, fault and snap_valid are 0 the same cycle without a clock edge; after release with en=1, a new scan starts at sel=0.
6. Drop en during sel=1 -> the scan completes and publishes; no further req until en=1 again.
